// File: rtl/eink_pixel_source.sv
// eink_pixel_source: generates one frame of packed 1-bpp pixel bytes from a
// selectable test pattern and hands them to the SPI sequencer over valid/ready.
// Optional build macro: PATTERN_LFSR_EN (pattern bit7 becomes LFSR noise).
module eink_pixel_source #(
    parameter int BYTES_PER_ROW = 16,
    parameter int ROWS          = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pattern_sel,
    input  logic        abort,
    input  logic        byte_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_count
);

    localparam int CW = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_COL   = CW'(BYTES_PER_ROW - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [15:0]   LAST_COL16 = 16'(BYTES_PER_ROW - 1);
    localparam logic [15:0]   LAST_ROW16 = 16'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_valid;
    logic [7:0]      r_data;
    logic [15:0]     r_count;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [2:0]      r_idx;

    logic            w_accept;
    logic            w_hs;
    logic            w_last;
    logic            w_col_wrap;
    logic [CW-1:0]   w_col_nx;
    logic [RW-1:0]   w_row_nx;
    logic [7:0]      w_load_byte;
    logic [7:0]      w_next_byte;

    // Lowest set bit of the select wins.
    function automatic logic [2:0] prio_idx(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Pixel byte for pattern idx at (row r, byte column c). 1 = white, MSB = leftmost.
    function automatic logic [7:0] pat_byte(input logic [2:0] idx,
                                            input logic [RW-1:0] r,
                                            input logic [CW-1:0] c);
        logic [15:0] rr;
        logic [15:0] cc;
        logic [7:0]  b;
        rr = 16'(r);
        cc = 16'(c);
        case (idx)
            3'd0: b = 8'hFF;
            3'd1: b = 8'h00;
            3'd2: b = {8{cc[0]}};
            3'd3: b = {8{rr[3]}};
            3'd4: b = {8{cc[0] ^ rr[3]}};
            3'd5: b = {8{cc[1] ^ rr[4]}};
            3'd6: begin
                if (rr == 16'd0 || rr == LAST_ROW16) b = 8'h00;
                else if (cc == 16'd0)                b = 8'h7F;
                else if (cc == LAST_COL16)           b = 8'hFE;
                else                                 b = 8'hFF;
            end
            default: b = ~(8'h80 >> rr[2:0]);
        endcase
        return b;
    endfunction

    assign w_accept   = start && (pattern_sel != 8'd0);
    assign w_hs       = (r_state == S_STREAM) && r_valid && byte_ready;
    assign w_col_wrap = (r_col == LAST_COL);
    assign w_last     = w_col_wrap && (r_row == LAST_ROW);
    assign w_col_nx   = w_col_wrap ? '0 : r_col + CW'(1);
    assign w_row_nx   = w_col_wrap ? r_row + RW'(1) : r_row;

`ifdef PATTERN_LFSR_EN
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [15:0] w_lfsr_nx;
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_nx = {w_lfsr_fb, r_lfsr[15:1]};

    // LFSR seeds on frame accept and steps only on handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == S_IDLE) begin
            if (w_accept) r_lfsr <= 16'hACE1;
        end else if (w_hs && !abort && !w_last) begin
            r_lfsr <= w_lfsr_nx;
        end
    end
`endif

    // Byte for the current position (LOAD) and for the following position (handshake).
    always_comb begin
        w_load_byte = pat_byte(r_idx, r_row, r_col);
        w_next_byte = pat_byte(r_idx, w_row_nx, w_col_nx);
`ifdef PATTERN_LFSR_EN
        if (r_idx == 3'd7) begin
            w_load_byte = r_lfsr[7:0];
            w_next_byte = w_lfsr_nx[7:0];
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state and status outputs; abort outranks a simultaneous handshake.
    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) w_state_nx = S_LOAD;
            end
            S_LOAD: begin
                w_state_nx = abort ? S_IDLE : S_STREAM;
            end
            S_STREAM: begin
                if (abort)               w_state_nx = S_IDLE;
                else if (w_hs && w_last) w_state_nx = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Datapath: position counters, byte register and accepted-byte count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 8'hFF;
            r_count <= 16'd0;
            r_row   <= '0;
            r_col   <= '0;
            r_idx   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= prio_idx(pattern_sel);
                        r_row   <= '0;
                        r_col   <= '0;
                        r_count <= 16'd0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                        r_data  <= w_load_byte;
                    end
                end
                S_STREAM: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                    end else if (w_hs) begin
                        r_count <= r_count + 16'd1;
                        if (w_last) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_row  <= w_row_nx;
                            r_col  <= w_col_nx;
                            r_data <= w_next_byte;
                        end
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_data;
    assign byte_count = r_count;

endmodule

// File: tb/tb_eink_pixel_source.sv
// Bench for eink_pixel_source: frame-level reference model plus per-cycle compare.
module tb_eink_pixel_source;

    localparam int BPR   = 16;
    localparam int ROWS  = 256;
    localparam int FRAME = BPR * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pattern_sel;
    logic        abort;
    logic        byte_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        busy;
    logic        done;
    logic [15:0] byte_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_busy, m_load, m_valid, m_done;
    int m_cnt, m_pat;
    bit chk_en = 1'b0;

`ifdef PATTERN_LFSR_EN
    logic [7:0] lfsr_tab [FRAME];
`endif

    eink_pixel_source #(.BYTES_PER_ROW(BPR), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel),
        .abort(abort), .byte_ready(byte_ready), .byte_valid(byte_valid),
        .byte_data(byte_data), .busy(busy), .done(done), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int lowest_bit(input logic [7:0] s);
        for (int i = 0; i < 8; i++) if (s[i]) return i;
        return 0;
    endfunction

    // Expected k-th byte of a frame for pattern p, straight from the pattern rules.
    function automatic logic [7:0] ref_byte(input int p, input int k);
        int r, c;
        logic [7:0] d;
        r = k / BPR;
        c = k % BPR;
        case (p)
            0: return 8'hFF;
            1: return 8'h00;
            2: return (c % 2) ? 8'hFF : 8'h00;
            3: return ((r / 8) % 2) ? 8'hFF : 8'h00;
            4: return (((c % 2) + (r / 8)) % 2) ? 8'hFF : 8'h00;
            5: return ((((c / 2) % 2) + ((r / 16) % 2)) % 2) ? 8'hFF : 8'h00;
            6: begin
                if (r == 0 || r == ROWS - 1) return 8'h00;
                if (c == 0)                  return 8'h7F;
                if (c == BPR - 1)            return 8'hFE;
                return 8'hFF;
            end
            default: begin
`ifdef PATTERN_LFSR_EN
                return lfsr_tab[k];
`else
                d = 8'h80 >> (r % 8);
                return ~d;
`endif
            end
        endcase
    endfunction

    // Compare outputs against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_load = 0; m_valid = 0; m_done = 0; m_cnt = 0; m_pat = 0;
        end else if (chk_en) begin
            check("valid", byte_valid, m_valid);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("count", byte_count, m_cnt);
            if (m_valid) check("data", byte_data, ref_byte(m_pat, m_cnt));
            if (!m_busy) begin
                if (start && pattern_sel != 8'd0) begin
                    m_busy = 1; m_load = 1; m_valid = 0; m_cnt = 0;
                    m_pat = lowest_bit(pattern_sel);
                end
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (abort) begin
                m_busy = 0; m_load = 0; m_valid = 0;
            end else if (m_load) begin
                m_load = 0; m_valid = 1;
            end else if (m_valid && byte_ready) begin
                m_cnt++;
                if (m_cnt == FRAME) begin
                    m_valid = 0; m_done = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] sel, input bit rnd, input bit poke);
        bit seen;
        pattern_sel = sel;
        start       = 1'b1;
        byte_ready  = rnd ? ($urandom % 4 != 0) : 1'b1;
        cyc();
        start = 1'b0;
        check("load_gap", byte_valid, 1'b0);
        cyc();
        check("first_valid", byte_valid, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 3 * FRAME + 100 && !seen; n++) begin
            byte_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
            if (poke && n == 50) begin
                start = 1'b1; pattern_sel = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (poke && n == 200) pattern_sel = 8'h02;
            cyc();
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("final_count", byte_count, FRAME);
        cyc();
        check("idle_after", busy, 1'b0);
    endtask

    initial begin
        bit hit;
        int s, fb;
        rst = 1'b1; start = 1'b0; abort = 1'b0; byte_ready = 1'b0; pattern_sel = 8'h00;

`ifdef PATTERN_LFSR_EN
        s = 16'hACE1;
        for (int k = 0; k < FRAME; k++) begin
            lfsr_tab[k] = 8'(s & 8'hFF);
            fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s  = (s >> 1) | (fb << 15);
        end
        check("pin_lfsr0", ref_byte(7, 0), 8'hE1);
        check("pin_lfsr1", ref_byte(7, 1), 8'h70);
`else
        s = 0; fb = 0;
        check("pin_diag0", ref_byte(7, 0), 8'h7F);
        check("pin_diag16", ref_byte(7, 16), 8'hBF);
        check("pin_diag_r7", ref_byte(7, 7 * BPR), 8'hFE);
`endif
        check("pin_stripe1", ref_byte(2, 1), 8'hFF);
        check("pin_stripe16", ref_byte(2, 16), 8'h00);
        check("pin_box_r1c0", ref_byte(6, 16), 8'h7F);
        check("pin_box_r1c15", ref_byte(6, 31), 8'hFE);
        check("pin_box_r0", ref_byte(6, 5), 8'h00);
        check("pin_box_last", ref_byte(6, FRAME - 1), 8'h00);
        check("pin_chk8", ref_byte(4, 8 * BPR), 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", byte_valid, 1'b0);
        check("rst_data", byte_data, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", byte_count, 16'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc();

        run_frame(8'h01, 1'b0, 1'b0);
        run_frame(8'h14, 1'b0, 1'b0);
        run_frame(8'h40, 1'b1, 1'b0);

        // Abort after exactly 100 accepted bytes
        pattern_sel = 8'h10; start = 1'b1; byte_ready = 1'b1;
        cyc();
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            cyc();
            if (byte_count == 16'd100) hit = 1'b1;
        end
        check("abort_reach", hit, 1'b1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_valid", byte_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_count", byte_count, 16'd100);
        run_frame(8'h02, 1'b0, 1'b0);

        // start with an empty select is ignored
        pattern_sel = 8'h00; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        check("nosel_busy", busy, 1'b0);
        check("nosel_valid", byte_valid, 1'b0);
        check("nosel_count", byte_count, FRAME);

        run_frame(8'h08, 1'b1, 1'b1);
        run_frame(8'h80, 1'b1, 1'b0);
        run_frame(8'h20, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
